// File: rtl/serial_fifo_bridge_pkg.sv
// Shared types and width helpers for the serial FIFO bridge.
// The bridge, its FIFOs and the bench all import this package.
package serial_fifo_bridge_pkg;

    localparam int DATA_W        = 8;
    localparam int DEFAULT_DEPTH = 4;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_SEND = 1'b1
    } tx_state_t;

    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

    // The count needs one more bit than a pointer so that "full" (== depth) can be represented.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/serial_fifo_bridge_if.sv
// Byte-level handshake bundle between the UART side, the CPU datapath side and the bridge.
interface serial_fifo_bridge_if;
    import serial_fifo_bridge_pkg::*;

    logic [DATA_W-1:0] rx_data_in;
    logic              rx_valid_in;
    logic [DATA_W-1:0] cpu_rd_data_out;
    logic              cpu_rd_valid_out;
    logic              cpu_rd_en_in;
    logic [DATA_W-1:0] cpu_wr_data_in;
    logic              cpu_wr_en_in;
    logic              cpu_wr_ready_out;
    logic [DATA_W-1:0] tx_data_out;
    logic              tx_valid_out;
    logic              tx_ready_in;
    logic              clear_in;
    logic              rx_overflow_out;
    logic              tx_overflow_out;

    modport slave (
        input  rx_data_in, rx_valid_in, cpu_rd_en_in, cpu_wr_data_in, cpu_wr_en_in,
               tx_ready_in, clear_in,
        output cpu_rd_data_out, cpu_rd_valid_out, cpu_wr_ready_out, tx_data_out,
               tx_valid_out, rx_overflow_out, tx_overflow_out
    );

    modport master (
        output rx_data_in, rx_valid_in, cpu_rd_en_in, cpu_wr_data_in, cpu_wr_en_in,
               tx_ready_in, clear_in,
        input  cpu_rd_data_out, cpu_rd_valid_out, cpu_wr_ready_out, tx_data_out,
               tx_valid_out, rx_overflow_out, tx_overflow_out
    );

endinterface

// File: rtl/serial_fifo_bridge_sync_fifo.sv
// Show-ahead synchronous FIFO: head is always the oldest entry, read straight from storage.
// A push into a full FIFO still succeeds when a pop happens on the same edge.
module sync_fifo
    import serial_fifo_bridge_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        push,
    input  logic                        pop,
    input  logic [WIDTH-1:0]            push_data,
    output logic [WIDTH-1:0]            head,
    output logic                        full,
    output logic                        empty,
    output logic [cnt_width(DEPTH)-1:0] count
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int CNT_W = cnt_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/serial_fifo_bridge.sv
// Buffers UART RX bytes for the CPU and drains CPU TX bytes to the UART through an output register.
// Reset is asynchronous and active-low.
module serial_fifo_bridge
    import serial_fifo_bridge_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input logic               clock,
    input logic               reset,
    serial_fifo_bridge_if.slave bus
);

    localparam int CNT_W = cnt_width(DEPTH);

    logic [DATA_W-1:0] tx_head;
    logic              rx_full;
    logic              rx_empty;
    logic              tx_full;
    logic              tx_empty;
    logic [CNT_W-1:0]  rx_count;
    logic [CNT_W-1:0]  tx_count;
    logic              tx_pop;
    logic              rx_drop;
    logic              tx_drop;
    tx_state_t         state;

    sync_fifo #(.WIDTH(DATA_W), .DEPTH(DEPTH)) u_rx_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (bus.rx_valid_in),
        .pop       (bus.cpu_rd_en_in),
        .push_data (bus.rx_data_in),
        .head      (bus.cpu_rd_data_out),
        .full      (rx_full),
        .empty     (rx_empty),
        .count     (rx_count)
    );

    sync_fifo #(.WIDTH(DATA_W), .DEPTH(DEPTH)) u_tx_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (bus.cpu_wr_en_in),
        .pop       (tx_pop),
        .push_data (bus.cpu_wr_data_in),
        .head      (tx_head),
        .full      (tx_full),
        .empty     (tx_empty),
        .count     (tx_count)
    );

    assign bus.cpu_rd_valid_out = (rx_count != '0);
    assign bus.cpu_wr_ready_out = (tx_count < CNT_W'(DEPTH));

    // The output register frees up either when idle or when the UART takes the current byte.
    assign tx_pop  = !tx_empty && ((state == TX_IDLE) || bus.tx_ready_in);
    assign rx_drop = bus.rx_valid_in && rx_full && !(bus.cpu_rd_en_in && !rx_empty);
    assign tx_drop = bus.cpu_wr_en_in && tx_full && !tx_pop;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state            <= TX_IDLE;
            bus.tx_valid_out <= 1'b0;
            bus.tx_data_out  <= '0;
        end else begin
            case (state)
                TX_IDLE: begin
                    if (!tx_empty) begin
                        bus.tx_data_out  <= tx_head;
                        bus.tx_valid_out <= 1'b1;
                        state            <= TX_SEND;
                    end
                end
                TX_SEND: begin
                    if (bus.tx_ready_in) begin
                        if (!tx_empty) begin
                            bus.tx_data_out <= tx_head;
                        end else begin
                            bus.tx_valid_out <= 1'b0;
                            state            <= TX_IDLE;
                        end
                    end
                end
                default: begin
                    state            <= TX_IDLE;
                    bus.tx_valid_out <= 1'b0;
                end
            endcase
        end
    end

    // A drop on the same edge as a clear leaves the flag set.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bus.rx_overflow_out <= 1'b0;
            bus.tx_overflow_out <= 1'b0;
        end else begin
            if (rx_drop) begin
                bus.rx_overflow_out <= 1'b1;
            end else if (bus.clear_in) begin
                bus.rx_overflow_out <= 1'b0;
            end
            if (tx_drop) begin
                bus.tx_overflow_out <= 1'b1;
            end else if (bus.clear_in) begin
                bus.tx_overflow_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_serial_fifo_bridge.sv
// Self-checking bench for serial_fifo_bridge: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_serial_fifo_bridge;
    import serial_fifo_bridge_pkg::*;

    localparam int DEPTH = DEFAULT_DEPTH;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    serial_fifo_bridge_if bus ();

    serial_fifo_bridge #(.DEPTH(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    logic [7:0] rx_q [$];
    logic [7:0] tx_q [$];
    logic       m_tx_valid;
    logic [7:0] m_tx_data;
    logic       m_rx_ovf;
    logic       m_tx_ovf;

    task automatic model_reset();
        rx_q.delete();
        tx_q.delete();
        m_tx_valid = 1'b0;
        m_tx_data  = 8'h00;
        m_rx_ovf   = 1'b0;
        m_tx_ovf   = 1'b0;
    endtask

    task automatic idle_inputs();
        bus.rx_data_in     = 8'h00;
        bus.rx_valid_in    = 1'b0;
        bus.cpu_rd_en_in   = 1'b0;
        bus.cpu_wr_data_in = 8'h00;
        bus.cpu_wr_en_in   = 1'b0;
        bus.tx_ready_in    = 1'b0;
        bus.clear_in       = 1'b0;
    endtask

    // One clock edge: the model consumes the inputs that were stable at that edge, then sampling moves 1ns past it.
    task automatic tick();
        int rx_n;
        int tx_n;
        bit rx_pop;
        bit rx_push;
        bit tx_pop;
        bit tx_push;
        @(posedge clock);
        rx_n    = rx_q.size();
        tx_n    = tx_q.size();
        rx_pop  = bus.cpu_rd_en_in && (rx_n > 0);
        rx_push = bus.rx_valid_in && ((rx_n < DEPTH) || rx_pop);
        tx_pop  = (!m_tx_valid || bus.tx_ready_in) && (tx_n > 0);
        tx_push = bus.cpu_wr_en_in && ((tx_n < DEPTH) || tx_pop);
        if (bus.rx_valid_in && !rx_push) m_rx_ovf = 1'b1;
        else if (bus.clear_in)           m_rx_ovf = 1'b0;
        if (bus.cpu_wr_en_in && !tx_push) m_tx_ovf = 1'b1;
        else if (bus.clear_in)            m_tx_ovf = 1'b0;
        if (rx_pop)  void'(rx_q.pop_front());
        if (rx_push) rx_q.push_back(bus.rx_data_in);
        if (tx_pop) begin
            m_tx_data  = tx_q.pop_front();
            m_tx_valid = 1'b1;
        end else if (m_tx_valid && bus.tx_ready_in) begin
            m_tx_valid = 1'b0;
        end
        if (tx_push) tx_q.push_back(bus.cpu_wr_data_in);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        model_reset();
        #1 reset = 1'b0;
        #12;
        checks++; if (bus.cpu_rd_valid_out !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %b exp 0", bus.cpu_rd_valid_out); end
        checks++; if (bus.cpu_rd_data_out !== 8'h00) begin errors++; $display("FAIL reset_rd_data got %h exp 00", bus.cpu_rd_data_out); end
        checks++; if (bus.cpu_wr_ready_out !== 1'b1) begin errors++; $display("FAIL reset_wr_ready got %b exp 1", bus.cpu_wr_ready_out); end
        checks++; if (bus.tx_valid_out !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got %b exp 0", bus.tx_valid_out); end
        checks++; if (bus.tx_data_out !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %h exp 00", bus.tx_data_out); end
        checks++; if ({bus.rx_overflow_out, bus.tx_overflow_out} !== 2'b00) begin errors++; $display("FAIL reset_ovf got %b exp 00", {bus.rx_overflow_out, bus.tx_overflow_out}); end
        @(negedge clock) reset = 1'b1;
        tick();
    endtask

    task automatic test_rx_order();
        logic [7:0] exp;
        for (int i = 0; i < 3; i++) begin
            bus.rx_data_in  = 8'h41 + 8'(i);
            bus.rx_valid_in = 1'b1;
            tick();
        end
        bus.rx_valid_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp = 8'h41 + 8'(i);
            checks++; if (bus.cpu_rd_valid_out !== 1'b1) begin errors++; $display("FAIL rx_order_valid[%0d] got %b exp 1", i, bus.cpu_rd_valid_out); end
            checks++; if (bus.cpu_rd_data_out !== exp) begin errors++; $display("FAIL rx_order_data[%0d] got %h exp %h", i, bus.cpu_rd_data_out, exp); end
            bus.cpu_rd_en_in = 1'b1;
            tick();
        end
        bus.cpu_rd_en_in = 1'b0;
        checks++; if (bus.cpu_rd_valid_out !== 1'b0) begin errors++; $display("FAIL rx_order_empty got %b exp 0", bus.cpu_rd_valid_out); end
    endtask

    task automatic test_rx_overflow();
        logic [7:0] exp;
        for (int i = 0; i < 5; i++) begin
            bus.rx_data_in  = 8'h10 + 8'(i);
            bus.rx_valid_in = 1'b1;
            tick();
            if (i == 3) begin
                checks++; if (bus.rx_overflow_out !== 1'b0) begin errors++; $display("FAIL rx_ovf_early got %b exp 0", bus.rx_overflow_out); end
            end
        end
        bus.rx_valid_in = 1'b0;
        checks++; if (bus.rx_overflow_out !== 1'b1) begin errors++; $display("FAIL rx_ovf_set got %b exp 1", bus.rx_overflow_out); end
        tick();
        checks++; if (bus.rx_overflow_out !== 1'b1) begin errors++; $display("FAIL rx_ovf_sticky got %b exp 1", bus.rx_overflow_out); end
        bus.clear_in = 1'b1;
        tick();
        bus.clear_in = 1'b0;
        checks++; if (bus.rx_overflow_out !== 1'b0) begin errors++; $display("FAIL rx_ovf_clear got %b exp 0", bus.rx_overflow_out); end
        for (int i = 0; i < 4; i++) begin
            exp = 8'h10 + 8'(i);
            checks++; if (bus.cpu_rd_data_out !== exp) begin errors++; $display("FAIL rx_ovf_drain[%0d] got %h exp %h", i, bus.cpu_rd_data_out, exp); end
            bus.cpu_rd_en_in = 1'b1;
            tick();
        end
        bus.cpu_rd_en_in = 1'b0;
        checks++; if (bus.cpu_rd_valid_out !== 1'b0) begin errors++; $display("FAIL rx_ovf_dropped got valid %b exp 0", bus.cpu_rd_valid_out); end
    endtask

    task automatic test_simultaneous();
        logic [7:0] exp;
        for (int i = 0; i < 4; i++) begin
            bus.rx_data_in  = 8'h20 + 8'(i);
            bus.rx_valid_in = 1'b1;
            tick();
        end
        bus.rx_data_in   = 8'h24;
        bus.cpu_rd_en_in = 1'b1;
        tick();
        bus.cpu_rd_en_in = 1'b0;
        checks++; if (bus.rx_overflow_out !== 1'b0) begin errors++; $display("FAIL full_pushpop_ovf got %b exp 0", bus.rx_overflow_out); end
        checks++; if (bus.cpu_rd_data_out !== 8'h21) begin errors++; $display("FAIL full_pushpop_head got %h exp 21", bus.cpu_rd_data_out); end
        bus.rx_data_in = 8'h25;
        tick();
        bus.rx_valid_in = 1'b0;
        checks++; if (bus.rx_overflow_out !== 1'b1) begin errors++; $display("FAIL full_still_full got ovf %b exp 1", bus.rx_overflow_out); end
        bus.clear_in = 1'b1;
        tick();
        bus.clear_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp = 8'h21 + 8'(i);
            checks++; if (bus.cpu_rd_data_out !== exp) begin errors++; $display("FAIL full_drain[%0d] got %h exp %h", i, bus.cpu_rd_data_out, exp); end
            bus.cpu_rd_en_in = 1'b1;
            tick();
        end
        bus.rx_data_in  = 8'h30;
        bus.rx_valid_in = 1'b1;
        tick();
        bus.rx_valid_in = 1'b0;
        checks++; if ({bus.cpu_rd_valid_out, bus.cpu_rd_data_out} !== {1'b1, 8'h30}) begin errors++; $display("FAIL empty_pushpop got %b/%h exp 1/30", bus.cpu_rd_valid_out, bus.cpu_rd_data_out); end
        tick();
        bus.cpu_rd_en_in = 1'b0;
        checks++; if (bus.cpu_rd_valid_out !== 1'b0) begin errors++; $display("FAIL empty_pushpop_count got valid %b exp 0", bus.cpu_rd_valid_out); end
    endtask

    task automatic test_tx_back_to_back();
        logic       exp_valid [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [7:0] exp_data  [5] = '{8'h00, 8'hA0, 8'hA1, 8'hA2, 8'h00};
        bus.tx_ready_in = 1'b1;
        for (int t = 0; t < 5; t++) begin
            bus.cpu_wr_en_in   = (t < 3);
            bus.cpu_wr_data_in = 8'hA0 + 8'(t);
            tick();
            checks++; if (bus.tx_valid_out !== exp_valid[t]) begin errors++; $display("FAIL b2b_valid[%0d] got %b exp %b", t, bus.tx_valid_out, exp_valid[t]); end
            if (exp_valid[t]) begin
                checks++; if (bus.tx_data_out !== exp_data[t]) begin errors++; $display("FAIL b2b_data[%0d] got %h exp %h", t, bus.tx_data_out, exp_data[t]); end
            end
        end
        bus.cpu_wr_en_in = 1'b0;
        bus.tx_ready_in  = 1'b0;
    endtask

    task automatic test_tx_backpressure();
        logic [7:0] exp_seq [5] = '{8'h51, 8'h52, 8'h53, 8'h54, 8'h5F};
        bus.tx_ready_in = 1'b0;
        for (int i = 0; i < 6; i++) begin
            checks++; if (bus.cpu_wr_ready_out !== (i < 5)) begin errors++; $display("FAIL bp_ready[%0d] got %b exp %b", i, bus.cpu_wr_ready_out, (i < 5)); end
            bus.cpu_wr_en_in   = 1'b1;
            bus.cpu_wr_data_in = 8'h50 + 8'(i);
            tick();
        end
        bus.cpu_wr_en_in = 1'b0;
        checks++; if (bus.tx_overflow_out !== 1'b1) begin errors++; $display("FAIL bp_ovf got %b exp 1", bus.tx_overflow_out); end
        tick();
        tick();
        checks++; if ({bus.tx_valid_out, bus.tx_data_out} !== {1'b1, 8'h50}) begin errors++; $display("FAIL bp_hold got %b/%h exp 1/50", bus.tx_valid_out, bus.tx_data_out); end
        bus.clear_in = 1'b1;
        tick();
        bus.clear_in = 1'b0;
        bus.tx_ready_in    = 1'b1;
        bus.cpu_wr_en_in   = 1'b1;
        bus.cpu_wr_data_in = 8'h5F;
        tick();
        bus.cpu_wr_en_in = 1'b0;
        checks++; if (bus.tx_overflow_out !== 1'b0) begin errors++; $display("FAIL bp_pop_push_ovf got %b exp 0", bus.tx_overflow_out); end
        for (int i = 0; i < 5; i++) begin
            checks++; if ({bus.tx_valid_out, bus.tx_data_out} !== {1'b1, exp_seq[i]}) begin errors++; $display("FAIL bp_drain[%0d] got %b/%h exp 1/%h", i, bus.tx_valid_out, bus.tx_data_out, exp_seq[i]); end
            tick();
        end
        checks++; if (bus.tx_valid_out !== 1'b0) begin errors++; $display("FAIL bp_idle got %b exp 0", bus.tx_valid_out); end
        bus.tx_ready_in = 1'b0;
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            bus.rx_valid_in    = ($urandom_range(99, 0) < 50);
            bus.rx_data_in     = 8'($urandom);
            bus.cpu_rd_en_in   = ($urandom_range(99, 0) < 35);
            bus.cpu_wr_en_in   = ($urandom_range(99, 0) < 50);
            bus.cpu_wr_data_in = 8'($urandom);
            bus.tx_ready_in    = ($urandom_range(99, 0) < 40);
            bus.clear_in       = ($urandom_range(99, 0) < 6);
            tick();
            checks++; if (bus.cpu_rd_valid_out !== (rx_q.size() > 0)) begin errors++; $display("FAIL rand_rd_valid@%0d got %b exp %b", n, bus.cpu_rd_valid_out, (rx_q.size() > 0)); end
            if (rx_q.size() > 0) begin
                checks++; if (bus.cpu_rd_data_out !== rx_q[0]) begin errors++; $display("FAIL rand_rd_data@%0d got %h exp %h", n, bus.cpu_rd_data_out, rx_q[0]); end
            end
            checks++; if (bus.cpu_wr_ready_out !== (tx_q.size() < DEPTH)) begin errors++; $display("FAIL rand_wr_ready@%0d got %b exp %b", n, bus.cpu_wr_ready_out, (tx_q.size() < DEPTH)); end
            checks++; if (bus.tx_valid_out !== m_tx_valid) begin errors++; $display("FAIL rand_tx_valid@%0d got %b exp %b", n, bus.tx_valid_out, m_tx_valid); end
            if (m_tx_valid) begin
                checks++; if (bus.tx_data_out !== m_tx_data) begin errors++; $display("FAIL rand_tx_data@%0d got %h exp %h", n, bus.tx_data_out, m_tx_data); end
            end
            checks++; if ({bus.rx_overflow_out, bus.tx_overflow_out} !== {m_rx_ovf, m_tx_ovf}) begin errors++; $display("FAIL rand_ovf@%0d got %b exp %b", n, {bus.rx_overflow_out, bus.tx_overflow_out}, {m_rx_ovf, m_tx_ovf}); end
        end
        idle_inputs();
    endtask

    task automatic test_async_reset();
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            bus.cpu_wr_en_in   = 1'b1;
            bus.cpu_wr_data_in = 8'h70 + 8'(i);
            bus.rx_valid_in    = 1'b1;
            bus.rx_data_in     = 8'h60 + 8'(i);
            tick();
        end
        idle_inputs();
        checks++; if ({bus.tx_valid_out, bus.cpu_rd_valid_out} !== {m_tx_valid, (rx_q.size() > 0)}) begin errors++; $display("FAIL areset_pre got %b exp %b", {bus.tx_valid_out, bus.cpu_rd_valid_out}, {m_tx_valid, (rx_q.size() > 0)}); end
        #2 reset = 1'b0;
        #1;
        model_reset();
        checks++; if ({bus.tx_valid_out, bus.cpu_rd_valid_out} !== 2'b00) begin errors++; $display("FAIL areset_now got %b exp 00", {bus.tx_valid_out, bus.cpu_rd_valid_out}); end
        checks++; if ({bus.tx_data_out, bus.cpu_rd_data_out} !== 16'h0000) begin errors++; $display("FAIL areset_data got %h exp 0000", {bus.tx_data_out, bus.cpu_rd_data_out}); end
        checks++; if (bus.cpu_wr_ready_out !== 1'b1) begin errors++; $display("FAIL areset_wr_ready got %b exp 1", bus.cpu_wr_ready_out); end
        @(negedge clock) reset = 1'b1;
        bus.tx_ready_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if ({bus.tx_valid_out, bus.cpu_rd_valid_out} !== 2'b00) begin errors++; $display("FAIL areset_after[%0d] got %b exp 00", i, {bus.tx_valid_out, bus.cpu_rd_valid_out}); end
        end
        idle_inputs();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached checks=%0d errors=%0d", checks, errors);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_rx_order();
        test_rx_overflow();
        test_simultaneous();
        test_tx_back_to_back();
        test_tx_backpressure();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_fifo_bridge.md
SERIAL_FIFO_BRIDGE -- requirements
Module: serial_fifo_bridge

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving entries per FIFO; legal values are powers of two from 2 to 16.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset:
  clock  in  1  rising-edge clock
  reset  in  1  asynchronous active-low reset
REQ-003 The block SHALL have the following ports:
  rx_data_in  in  8  byte from UART receiver
  rx_valid_in  in  1  one-cycle strobe, rx_data_in valid
  cpu_rd_data_out  out  8  RX FIFO head byte, to datapath serial_in
  cpu_rd_valid_out  out  1  RX FIFO non-empty, to serial_valid_in
  cpu_rd_en_in  in  1  pop RX head, from serial_rden_out
  cpu_wr_data_in  in  8  byte to transmit, from serial_out
  cpu_wr_en_in  in  1  push TX byte, from serial_wren_out
  cpu_wr_ready_out  out  1  TX FIFO not full, to serial_ready_in
  tx_data_out  out  8  byte to UART transmitter
  tx_valid_out  out  1  tx_data_out valid
  tx_ready_in  in  1  UART transmitter accepts byte
  clear_in  in  1  clears sticky overflow flags
  rx_overflow_out  out  1  sticky, RX byte dropped
  tx_overflow_out  out  1  sticky, TX byte dropped

Function
REQ-004 RX push SHALL occur when rx_valid_in=1 and the RX FIFO is not full; rx_valid_in=1 while full SHALL drop the byte and set rx_overflow_out.
REQ-005 cpu_rd_data_out SHALL be the RX head entry, driven from registers (show-ahead); cpu_rd_valid_out SHALL be 1 iff the RX count is greater than 0.
REQ-006 RX pop SHALL occur when cpu_rd_en_in=1 and the RX count is greater than 0; cpu_rd_en_in while empty SHALL be ignored, with no error flag.
REQ-007 A pushed byte SHALL be visible on cpu_rd_data_out/cpu_rd_valid_out the cycle after the push edge (latency 1).
REQ-008 Simultaneous push and pop while full SHALL perform both, leaving the count unchanged and raising no overflow.
REQ-009 Simultaneous push and pop while empty SHALL accept the push and ignore the pop, leaving count=1.
REQ-010 TX push SHALL occur when cpu_wr_en_in=1 and the TX FIFO is not full; cpu_wr_en_in=1 while full SHALL drop the byte and set tx_overflow_out.
REQ-011 cpu_wr_ready_out SHALL be 1 iff the TX count is less than DEPTH; this is combinational from registered count.
REQ-012 Read/write pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH; count SHALL be log2(DEPTH)+1 bits, saturating never needed.
REQ-013 The TX drain FSM SHALL have two states, IDLE and SEND.
REQ-014 In IDLE with TX count greater than 0, the FSM SHALL load the head into the tx_data_out register, pop TX, set tx_valid_out=1 and go to SEND on that edge.
REQ-015 In SEND, tx_valid_out and tx_data_out SHALL hold stable until tx_ready_in=1.
REQ-016 On the SEND edge where tx_ready_in=1, if TX count is greater than 0 the FSM SHALL load and pop the next byte and stay in SEND (back-to-back, no bubble); otherwise it SHALL clear tx_valid_out and go to IDLE.
REQ-017 The TX FIFO plus the output register SHALL hold DEPTH+1 bytes total.
REQ-018 A TX pop by the FSM and a cpu push in the same cycle while full SHALL both succeed, with no overflow.
REQ-019 clear_in=1 SHALL clear both sticky flags on the next edge; an overflow event in the same cycle SHALL win, leaving the flag set.

Reset
REQ-020 Reset assertion SHALL immediately set FIFO pointers and counts to 0, FSM=IDLE, tx_valid_out=0, tx_data_out=0, and both overflow flags=0.
REQ-021 Therefore during reset cpu_rd_valid_out=0, cpu_rd_data_out=0 (storage reset to 0), and cpu_wr_ready_out=1.
REQ-022 Reset mid-transfer SHALL discard all buffered bytes; no partial byte SHALL be presented afterwards.

Structure
REQ-023 DEPTH-derived widths and FSM state encodings (IDLE=0, SEND=1) SHALL live in a shared header/package included by the bridge and the bench.
REQ-024 One sub-module, sync_fifo (parameterised width/depth, push/pop/full/empty/count, show-ahead head), SHALL be instantiated twice, once for RX and once for TX; the FSM and overflow logic SHALL reside in serial_fifo_bridge.

Verification
REQ-025 RX ordering: push 0x41,0x42,0x43 on consecutive cycles, then cpu_rd_en_in for 3 cycles -> cpu_rd_data_out reads 0x41,0x42,0x43 and cpu_rd_valid_out falls after the third pop.
REQ-026 RX overflow: DEPTH=4, push 5 bytes 0x10..0x14 with no pop -> 0x14 is dropped, rx_overflow_out=1 and stays 1; a clear_in pulse then returns it to 0.
REQ-027 TX back-to-back: write 0xA0,0xA1,0xA2 with tx_ready_in=1 constantly -> tx_valid_out is high for 3 consecutive cycles carrying 0xA0,0xA1,0xA2, then the FSM returns to IDLE.
REQ-028 TX backpressure: tx_ready_in=0, write 6 bytes -> 5 are accepted, cpu_wr_ready_out=0 after the 5th, the 6th sets tx_overflow_out, and tx_data_out holds the first byte stable.
REQ-029 Simultaneous events: RX full plus push+pop in the same cycle -> count stays 4 with no overflow; RX empty plus push+pop -> count becomes 1.
REQ-030 Async reset: assert reset low mid-SEND between edges -> tx_valid_out=0 and cpu_rd_valid_out=0 immediately; after release the FIFOs are empty.
